// File: rtl/forwarder_arbiter.sv
// Round-robin arbiter sharing one axistream forwarder between N_BUFS packetmem
// buffers, granting at packet granularity and steering read enable/data/done.
module forwarder_arbiter #(
  parameter int N_BUFS     = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_BUFS-1:0]            buf_ready,
  input  logic [N_BUFS*32-1:0]         buf_len,
  input  logic [N_BUFS*64-1:0]         buf_rd_data,
  output logic [N_BUFS*ADDR_WIDTH-1:0] buf_rd_addr,
  output logic [N_BUFS-1:0]            buf_rd_en,
  output logic [N_BUFS-1:0]            buf_done,
  input  logic [ADDR_WIDTH-1:0]        fwd_rd_addr,
  input  logic                         fwd_rd_en,
  input  logic                         fwd_done,
  output logic                         fwd_ready,
  output logic [31:0]                  fwd_len,
  output logic [63:0]                  fwd_rd_data,
  output logic                         grant_valid,
  output logic [SEL_WIDTH-1:0]         grant_idx,
  output logic [31:0]                  pkt_count
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [SEL_WIDTH-1:0]  r_grant_idx;
  logic [SEL_WIDTH-1:0]  r_last_grant;
  logic [SEL_WIDTH-1:0]  r_data_sel;
  logic [31:0]           r_pkt_count;
  logic [SEL_WIDTH-1:0]  w_pick;
  logic                  w_found;
  logic [N_BUFS-1:0]     w_grant_oh;
  logic                  w_ready_g;
  logic                  w_release;

  // Round-robin search: walk distances from farthest to nearest so the nearest ready buffer wins.
  always_comb begin
    w_pick  = r_grant_idx;
    w_found = |buf_ready;
    for (int k = N_BUFS; k >= 1; k--) begin
      for (int i = 0; i < N_BUFS; i++) begin
        w_pick = ((((int'(r_last_grant) + k) % N_BUFS) == i) && buf_ready[i]) ?
                 SEL_WIDTH'(i) : w_pick;
      end
    end
  end

  // Grant decode and per-buffer steering; non-granted buffers see nothing but the shared address.
  always_comb begin
    fwd_len     = 32'd0;
    fwd_rd_data = 64'd0;
    for (int i = 0; i < N_BUFS; i++) begin
      w_grant_oh[i] = (r_state == ST_LOCKED) && (r_grant_idx == SEL_WIDTH'(i));
      fwd_len       = fwd_len | (buf_len[32*i +: 32] & {32{w_grant_oh[i]}});
      fwd_rd_data   = fwd_rd_data |
                      (buf_rd_data[64*i +: 64] & {64{r_data_sel == SEL_WIDTH'(i)}});
      buf_rd_addr[ADDR_WIDTH*i +: ADDR_WIDTH] = fwd_rd_addr;
    end
    w_ready_g   = |(w_grant_oh & buf_ready);
    w_release   = w_ready_g & fwd_done & fwd_rd_en;
    buf_rd_en   = w_grant_oh & {N_BUFS{fwd_rd_en}};
    buf_done    = w_grant_oh & buf_ready & {N_BUFS{fwd_done & fwd_rd_en}};
    fwd_ready   = w_ready_g;
    grant_valid = (r_state == ST_LOCKED);
  end

  // Next-state logic: a grant is held until its packet's final read is accepted.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   w_state_next = w_found   ? ST_LOCKED : ST_IDLE;
      ST_LOCKED: w_state_next = w_release ? ST_IDLE   : ST_LOCKED;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // State, grant bookkeeping and packet counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant_idx  <= '0;
      r_last_grant <= SEL_WIDTH'(N_BUFS - 1);
      r_data_sel   <= '0;
      r_pkt_count  <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ST_IDLE) && w_found) begin
        r_grant_idx <= w_pick;
      end
      // data_sel lags the grant so the last word after release still comes from the old buffer
      if ((r_state == ST_LOCKED) && fwd_rd_en) begin
        r_data_sel <= r_grant_idx;
      end
      if (w_release) begin
        r_last_grant <= r_grant_idx;
        r_pkt_count  <= r_pkt_count + 32'd1;
      end
    end
  end

  assign grant_idx = r_grant_idx;
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_forwarder_arbiter.sv
// Directed bench for forwarder_arbiter: packet sequences with hand-computed
// grants, read steering, done pulses, data return and packet counting.
module tb_forwarder_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    buf_ready;
  logic [N*32-1:0] buf_len;
  logic [N*64-1:0] buf_rd_data;
  logic [N*AW-1:0] buf_rd_addr;
  logic [N-1:0]    buf_rd_en;
  logic [N-1:0]    buf_done;
  logic [AW-1:0]   fwd_rd_addr;
  logic            fwd_rd_en;
  logic            fwd_done;
  logic            fwd_ready;
  logic [31:0]     fwd_len;
  logic [63:0]     fwd_rd_data;
  logic            grant_valid;
  logic [SW-1:0]   grant_idx;
  logic [31:0]     pkt_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] mem_q [N];

  forwarder_arbiter #(.N_BUFS(N), .ADDR_WIDTH(AW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .buf_ready(buf_ready), .buf_len(buf_len), .buf_rd_data(buf_rd_data),
    .buf_rd_addr(buf_rd_addr), .buf_rd_en(buf_rd_en), .buf_done(buf_done),
    .fwd_rd_addr(fwd_rd_addr), .fwd_rd_en(fwd_rd_en), .fwd_done(fwd_done),
    .fwd_ready(fwd_ready), .fwd_len(fwd_len), .fwd_rd_data(fwd_rd_data),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word(input int i, input int a);
    return 64'hC0DE_0000_0000_0000 | (64'(i) << 32) | 64'(a);
  endfunction

  // Packetmem model: one-cycle read latency per buffer.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (buf_rd_en[i]) mem_q[i] <= word(i, int'(buf_rd_addr[i*AW +: AW]));
    end
  end
  assign buf_rd_data = {mem_q[3], mem_q[2], mem_q[1], mem_q[0]};

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd_word(input int g, input int w, input bit last);
    fwd_rd_addr = AW'(w);
    fwd_rd_en   = 1'b1;
    fwd_done    = last;
    #1;
    chk("rd_en", 64'(buf_rd_en), 64'(1 << g));
    chk("done", 64'(buf_done), last ? 64'(1 << g) : 64'd0);
    for (int i = 0; i < N; i++) chk("rd_addr", 64'(buf_rd_addr[i*AW +: AW]), 64'(w));
    tick();
    chk("rd_data", fwd_rd_data, word(g, w));
  endtask

  task automatic do_packet(input int g, input int len);
    tick();
    chk("grant_valid", 64'(grant_valid), 64'd1);
    chk("grant_idx", 64'(grant_idx), 64'(g));
    chk("fwd_ready", 64'(fwd_ready), 64'd1);
    chk("fwd_len", 64'(fwd_len), 64'(len));
    for (int w = 0; w < len; w++) rd_word(g, w, w == len - 1);
    fwd_rd_en = 1'b0;
    fwd_done  = 1'b0;
    #1;
    chk("idle_valid", 64'(grant_valid), 64'd0);
    chk("idle_rd_en", 64'(buf_rd_en), 64'd0);
  endtask

  initial begin
    rst = 1'b1; buf_ready = '0; buf_len = '0;
    fwd_rd_addr = '0; fwd_rd_en = 1'b0; fwd_done = 1'b0;
    tick(); tick();
    chk("rst_valid", 64'(grant_valid), 64'd0);
    chk("rst_idx", 64'(grant_idx), 64'd0);
    chk("rst_pkt", 64'(pkt_count), 64'd0);
    chk("rst_ready", 64'(fwd_ready), 64'd0);
    chk("rst_len", 64'(fwd_len), 64'd0);
    rst = 1'b0;

    // Single packet on buffer 0, length 3
    buf_ready = 4'b0001;
    buf_len[0*32 +: 32] = 32'd3;
    do_packet(0, 3);
    chk("t1_pkt", 64'(pkt_count), 64'd1);

    // All ready, len 2: grant order 0,1,2,3,0 from reset
    rst = 1'b1;
    buf_ready = 4'b1111;
    for (int i = 0; i < N; i++) buf_len[i*32 +: 32] = 32'd2;
    tick();
    rst = 1'b0;
    chk("t2_rst_pkt", 64'(pkt_count), 64'd0);
    do_packet(0, 2);
    do_packet(1, 2);
    do_packet(2, 2);
    do_packet(3, 2);
    do_packet(0, 2);
    chk("t2_pkt", 64'(pkt_count), 64'd5);

    // Buffer 2 drops ready mid-packet for 3 cycles
    buf_ready = 4'b0100;
    buf_len[2*32 +: 32] = 32'd4;
    tick();
    chk("t3_idx", 64'(grant_idx), 64'd2);
    chk("t3_len", 64'(fwd_len), 64'd4);
    rd_word(2, 0, 1'b0);
    rd_word(2, 1, 1'b0);
    buf_ready = 4'b0000;
    fwd_rd_en = 1'b0;
    repeat (3) begin
      #1;
      chk("t3_stall_ready", 64'(fwd_ready), 64'd0);
      chk("t3_stall_valid", 64'(grant_valid), 64'd1);
      chk("t3_stall_idx", 64'(grant_idx), 64'd2);
      chk("t3_stall_done", 64'(buf_done), 64'd0);
      tick();
    end
    buf_ready = 4'b0100;
    rd_word(2, 2, 1'b0);
    rd_word(2, 3, 1'b1);
    fwd_rd_en = 1'b0; fwd_done = 1'b0;
    buf_ready = 4'b1000;
    #1;
    chk("t3_idle", 64'(grant_valid), 64'd0);
    chk("t3_pkt", 64'(pkt_count), 64'd6);

    // Forwarder waits at the last address with rd_en low for 5 cycles
    buf_len[3*32 +: 32] = 32'd2;
    tick();
    chk("t4_idx", 64'(grant_idx), 64'd3);
    rd_word(3, 0, 1'b0);
    fwd_rd_addr = AW'(1); fwd_done = 1'b1; fwd_rd_en = 1'b0;
    repeat (5) begin
      #1;
      chk("t4_hold_done", 64'(buf_done), 64'd0);
      chk("t4_hold_valid", 64'(grant_valid), 64'd1);
      tick();
    end
    rd_word(3, 1, 1'b1);
    fwd_rd_en = 1'b0; fwd_done = 1'b0;
    buf_ready = 4'b0010;
    #1;
    chk("t4_idle_done", 64'(buf_done), 64'd0);
    chk("t4_pkt", 64'(pkt_count), 64'd7);

    // Reset mid-packet on buffer 1, then buffers 1 and 2 ready
    buf_len[1*32 +: 32] = 32'd3;
    tick();
    chk("t5_idx", 64'(grant_idx), 64'd1);
    rd_word(1, 0, 1'b0);
    rst = 1'b1; fwd_rd_en = 1'b0;
    buf_ready = 4'b0110;
    tick();
    chk("t5_rst_valid", 64'(grant_valid), 64'd0);
    chk("t5_rst_rd_en", 64'(buf_rd_en), 64'd0);
    chk("t5_rst_pkt", 64'(pkt_count), 64'd0);
    chk("t5_rst_idx", 64'(grant_idx), 64'd0);
    rst = 1'b0;
    do_packet(1, 3);
    chk("t5_pkt", 64'(pkt_count), 64'd1);

    // Packet counter wraps from all-ones
    buf_ready = 4'b0001;
    buf_len[0*32 +: 32] = 32'd1;
    force dut.r_pkt_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_pkt_count;
    #1;
    chk("t6_preset", 64'(pkt_count), 64'hFFFF_FFFF);
    do_packet(0, 1);
    chk("t6_wrap", 64'(pkt_count), 64'd0);
    buf_ready = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/forwarder_arbiter.md
Name: forwarder_arbiter

Overview:
- Shares one axistream forwarder between N_BUFS packetmem buffers, each of which may independently hold a ready packet.
- Sits between the packetmem instances and the single forwarder.
- Arbitrates round-robin at packet granularity, steers the forwarder's read port to the granted buffer, and returns the buffer's read data and length.
- Routes the done pulse back to the granted buffer only.

Parameters:
N_BUFS, 4, number of packetmem buffers (2..16)
ADDR_WIDTH, 10, packetmem read address width
SEL_WIDTH, 2, width of grant index, >= clog2(N_BUFS)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
buf_ready  in  N_BUFS  per-buffer ready_for_forwarder
buf_len  in  N_BUFS*32  per-buffer packet length in 64-bit words, buffer i at [32*i+:32]
buf_rd_data  in  N_BUFS*64  per-buffer read data, one-cycle memory latency
buf_rd_addr  out  N_BUFS*ADDR_WIDTH  per-buffer read address
buf_rd_en  out  N_BUFS  per-buffer read enable
buf_done  out  N_BUFS  per-buffer forwarder_done pulse
fwd_rd_addr  in  ADDR_WIDTH  forwarder read address
fwd_rd_en  in  1  forwarder read enable
fwd_done  in  1  forwarder done (high while last address presented)
fwd_ready  out  1  ready_for_forwarder to the forwarder
fwd_len  out  32  len_to_forwarder
fwd_rd_data  out  64  read data to the forwarder
grant_valid  out  1  high while a buffer is granted
grant_idx  out  SEL_WIDTH  granted buffer index
pkt_count  out  32  packets completed since reset, wraps at 2^32

Behaviour:
- FSM states: IDLE and LOCKED.
- Registers: state, grant_idx, last_grant, data_sel, pkt_count.

IDLE:
- grant_valid=0, fwd_ready=0, all buf_rd_en=0, all buf_done=0, fwd_len=0.
- If any buf_ready bit is set, pick the first set bit searching last_grant+1, last_grant+2, ... modulo N_BUFS.
- Load that index into grant_idx and go to LOCKED next cycle, giving 1 cycle of arbitration latency.

LOCKED (g = grant_idx):
- grant_valid=1, fwd_ready=buf_ready[g], fwd_len=buf_len[g].
- buf_rd_en[g]=fwd_rd_en; all other buf_rd_en=0.
- buf_done[g]=fwd_done & fwd_rd_en & buf_ready[g]; all other buf_done=0. This gives exactly one pulse per packet even if the forwarder stalls on the last word.
- Exit on fwd_done & fwd_rd_en & buf_ready[g]:
  - go to IDLE next cycle;
  - last_grant <= g;
  - pkt_count += 1.
- If buf_ready[g] drops mid-packet, stay LOCKED with fwd_ready low (the forwarder stalls). No regrant occurs until the packet completes.

Fixed routing:
- All buf_rd_addr slices = fwd_rd_addr at all times; only rd_en is steered.

Data select:
- data_sel <= g on every cycle with fwd_rd_en high in LOCKED. It holds otherwise.
- fwd_rd_data = buf_rd_data slice data_sel, combinational mux.
- The last word's data, returned the cycle after the release, therefore still comes from the old buffer.

Back-to-back packets:
- Minimum one IDLE cycle between packets; no re-arbitration while LOCKED.

Fairness:
- A buffer continuously ready waits at most N_BUFS-1 packets.
- A single ready buffer is regranted every packet.

Simultaneous events:
- A ready rising on buffer g in the same cycle as its release is not granted until the next IDLE evaluation.

Precondition:
- buf_len >= 1 for any ready buffer. Behaviour for len 0 is unspecified.

Reset (any state, including mid-packet):
- state=IDLE, grant_idx=0, last_grant=N_BUFS-1 (buffer 0 has first priority), data_sel=0, pkt_count=0.
- Hence all rd_en/done/fwd_ready/grant_valid are 0 the cycle after reset.

Test Plan:
1. Reset, then buf_ready=0001, buf_len[0]=3, forwarder always issuing reads -> grant_valid high 1 cycle later, grant_idx=0; buf_rd_en[0] asserted for 3 reads at addr 0,1,2; buf_done[0] single pulse; pkt_count=1; fwd_rd_data equals buffer 0 data including the last word after release.
2. buf_ready=1111 held, all len=2 -> grant order 0,1,2,3,0; one IDLE cycle between packets; pkt_count=5; no buf_rd_en on non-granted buffers.
3. Buffer 2 granted with len=4, buf_ready[2] dropped for 3 cycles after word 1 -> fwd_ready low for those cycles; grant held; packet completes afterwards with exactly one buf_done[2] pulse.
4. Forwarder holds at the last address with fwd_rd_en low for 5 cycles, then asserts it -> buf_done pulses once only, in the rd_en cycle.
5. rst asserted mid-packet on buffer 1, then buf_ready=0110 -> after reset, buffer 1 granted first (search from 0); pkt_count restarts from 0.
6. pkt_count preset via force to 0xFFFFFFFF, one packet completed -> pkt_count=0.
